// File: rtl/board_scan_ctrl_if.sv
// Layout handshake bundle between board_scan_ctrl and its consumer.
// SCAN_DIFF_EN adds the changed-square mask to the bundle.
interface board_scan_ctrl_if;
  logic [63:0] layout;
  logic        layout_valid;
  logic        layout_ready;
`ifdef SCAN_DIFF_EN
  logic [63:0] diff;

  modport master (
    output layout,
    output layout_valid,
    output diff,
    input  layout_ready
  );

  modport slave (
    input  layout,
    input  layout_valid,
    input  diff,
    output layout_ready
  );
`else
  modport master (
    output layout,
    output layout_valid,
    input  layout_ready
  );

  modport slave (
    input  layout,
    input  layout_valid,
    output layout_ready
  );
`endif
endinterface

// File: rtl/board_scan_ctrl.sv
// Row-scanned 8x8 board sensor with frame debounce and layout handshake.
// Optional macro SCAN_DIFF_EN adds a registered changed-square mask.
module board_scan_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [7:0] c,
  output logic [7:0] r,
  output logic       scanning,
  board_scan_ctrl_if.master bus
);

  localparam logic [3:0] SETTLE_LAST =
    4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] STABLE_MAX =
    3'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_COMPARE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_row;
  logic [3:0]  r_cnt;
  logic [63:0] r_frame;
  logic [63:0] r_cand;
  logic [2:0]  r_stab;
  logic        r_published;
  logic [63:0] r_layout;
  logic        r_valid;

  logic [5:0]  w_slot;
  logic        w_match;
  logic [63:0] w_cand_nxt;
  logic [2:0]  w_stab_nxt;
  logic        w_publish;
  logic        w_settled;

  // Row k lives at bit 56-8k, i.e. 8*(7-k)
  assign w_slot    = {~r_row, 3'b000};
  assign w_settled = (r_cnt == SETTLE_LAST);

  // ---------------- state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (scan_en) begin
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (w_settled) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (r_row == 3'd7) begin
          w_state_nxt = S_COMPARE;
        end else begin
          w_state_nxt = S_DRIVE;
        end
      end
      S_COMPARE: begin
        if (scan_en) begin
          w_state_nxt = S_DRIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------- outputs
  always_comb begin
    r        = 8'h00;
    scanning = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        r        = 8'h00;
        scanning = 1'b0;
      end
      S_DRIVE,
      S_SAMPLE: begin
        r        = 8'h01 << r_row;
        scanning = 1'b1;
      end
      S_COMPARE: begin
        r        = 8'h00;
        scanning = 1'b1;
      end
      default: begin
        r        = 8'h00;
        scanning = 1'b0;
      end
    endcase
  end

  // ---------------- row sequencing and capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row   <= 3'd0;
      r_cnt   <= 4'd0;
      r_frame <= 64'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_row <= 3'd0;
          r_cnt <= 4'd0;
        end
        S_DRIVE: begin
          if (w_settled) begin
            r_cnt <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_frame[w_slot +: 8] <= c;
          // Row 7 wraps to 0, ready for the next frame
          r_row <= r_row + 3'd1;
          r_cnt <= 4'd0;
        end
        S_COMPARE: begin
          r_row <= 3'd0;
          r_cnt <= 4'd0;
        end
        default: begin
          r_row <= 3'd0;
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  // ---------------- debounce
  assign w_match = (r_frame == r_cand);

  always_comb begin
    w_cand_nxt = r_cand;
    w_stab_nxt = r_stab;
    if (!w_match) begin
      w_cand_nxt = r_frame;
      w_stab_nxt = 3'd1;
    end else if (r_stab != STABLE_MAX) begin
      w_stab_nxt = r_stab + 3'd1;
    end
  end

  // First publish after reset goes out even if equal to layout
  assign w_publish =
    (r_state == S_COMPARE) &&
    (w_stab_nxt == STABLE_MAX) &&
    !r_valid &&
    ((w_cand_nxt != r_layout) || !r_published);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cand <= 64'd0;
      r_stab <= 3'd0;
    end else if (r_state == S_COMPARE) begin
      r_cand <= w_cand_nxt;
      r_stab <= w_stab_nxt;
    end
  end

  // ---------------- layout handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_layout    <= 64'd0;
      r_valid     <= 1'b0;
      r_published <= 1'b0;
    end else begin
      if (r_valid && bus.layout_ready) begin
        r_valid <= 1'b0;
      end else if (w_publish) begin
        r_valid <= 1'b1;
      end
      if (w_publish) begin
        r_layout    <= w_cand_nxt;
        r_published <= 1'b1;
      end
    end
  end

  assign bus.layout       = r_layout;
  assign bus.layout_valid = r_valid;

`ifdef SCAN_DIFF_EN
  logic [63:0] r_diff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_diff <= 64'd0;
    end else if (w_publish) begin
      r_diff <= w_cand_nxt ^ r_layout;
    end
  end

  assign bus.diff = r_diff;
`endif

endmodule

// File: tb/tb_board_scan_ctrl.sv
// Directed scoreboard bench for board_scan_ctrl.
// Diff checks are active when SCAN_DIFF_EN is defined.
module tb_board_scan_ctrl;

  localparam logic [63:0] START = 64'hFFFF_0000_0000_FFFF;
  localparam logic [63:0] B1    = 64'hFFFF_0000_1000_EFFF;
  localparam logic [63:0] B2    = 64'hFFFF_0100_1000_EFFF;
  localparam logic [63:0] BIT28 = 64'h0000_0000_1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic [7:0]  c;
  logic [7:0]  r;
  logic        scanning;
  logic [63:0] board;

  int          vecs = 0;
  int          errs = 0;
  logic [63:0] q[$];
  logic [63:0] prev_pub;

  board_scan_ctrl_if bus();

  board_scan_ctrl #(
    .SETTLE_CYCLES(4),
    .STABLE_FRAMES(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scan_en  (scan_en),
    .c        (c),
    .r        (r),
    .scanning (scanning),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Board model: driven row k returns slot k of the board image
  always @* begin
    c = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (r[k]) c = board[8*(7-k) +: 8];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("onehot", 64'($countones(r) <= 1), 64'd1);
  endtask

  task automatic wait_r(input logic [7:0] v,
                        input int lim);
    int n;
    n = 0;
    while (r !== v && n < lim) begin
      tick();
      n++;
    end
    chk("wait_r", 64'(r), 64'(v));
  endtask

  task automatic wait_pub(input int lim,
                          output int cyc);
    cyc = 0;
    while (bus.layout_valid !== 1'b1 && cyc < lim) begin
      tick();
      cyc++;
    end
    chk("pub_valid", 64'(bus.layout_valid), 64'd1);
  endtask

  task automatic take_pub();
    logic [63:0] e;
    chk("sb_depth", 64'(q.size() > 0), 64'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("layout", bus.layout, e);
`ifdef SCAN_DIFF_EN
      chk("diff", bus.diff, prev_pub ^ e);
`endif
      prev_pub = e;
    end
  endtask

  task automatic handshake();
    bus.layout_ready = 1'b1;
    tick();
    bus.layout_ready = 1'b0;
    chk("valid_clr", 64'(bus.layout_valid), 64'd0);
  endtask

  // Release reset and time the first publish, checking row timing
  task automatic run_from_reset(input string tag);
    int n;
    int p;
    logic [7:0] er;
    n = 0;
    reset = 1'b1;
    while (bus.layout_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n <= 82) begin
        p  = (n - 1) % 41;
        er = (p == 40) ? 8'h00 : (8'h01 << (p / 5));
        chk("row_timing", 64'(r), 64'(er));
      end
    end
    chk(tag, 64'(n), 64'd124);
  endtask

  initial begin
    int cyc;
    int k;
    logic seen;
    logic saw80;

    reset            = 1'b1;
    scan_en          = 1'b0;
    board            = 64'd0;
    bus.layout_ready = 1'b0;
    prev_pub         = 64'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_r",     64'(r),                64'd0);
    chk("rst_scan",  64'(scanning),         64'd0);
    chk("rst_layout", bus.layout,           64'd0);
    chk("rst_valid", 64'(bus.layout_valid), 64'd0);

    // Starting position
    board   = START;
    scan_en = 1'b1;
    q.push_back(START);
    @(negedge clk);
    @(negedge clk);
    run_from_reset("first_pub_lat");
    take_pub();
    handshake();

    // One-frame bounce on row 4
    wait_r(8'h00, 50);
    board = START | BIT28;
    repeat (41) tick();
    board = START;
    seen  = 1'b0;
    repeat (164) begin
      tick();
      if (bus.layout_valid) seen = 1'b1;
    end
    chk("bounce_nopub", 64'(seen), 64'd0);
    chk("bounce_layout", bus.layout, START);

    // Two stable changes under backpressure
    board = B1;
    q.push_back(B1);
    wait_pub(200, cyc);
    take_pub();
    board = B2;
    q.push_back(B2);
    repeat (250) tick();
    chk("bp_hold_valid", 64'(bus.layout_valid), 64'd1);
    chk("bp_hold_layout", bus.layout, B1);
    handshake();
    wait_pub(45, cyc);
    chk("bp_next_compare", 64'(cyc <= 41), 64'd1);
    take_pub();
    handshake();

    // scan_en drop during row 3
    wait_r(8'h04, 50);
    wait_r(8'h08, 10);
    scan_en = 1'b0;
    k     = 0;
    saw80 = 1'b0;
    while (scanning === 1'b1 && k < 60) begin
      tick();
      k++;
      if (r == 8'h80) saw80 = 1'b1;
    end
    chk("stop_len",  64'(k),        64'd26);
    chk("stop_row7", 64'(saw80),    64'd1);
    chk("stop_r",    64'(r),        64'd0);
    repeat (5) tick();
    chk("idle_scan", 64'(scanning), 64'd0);
    chk("idle_r",    64'(r),        64'd0);

    // Pending publish, then reset during row 5
    scan_en = 1'b1;
    board   = START;
    q.push_back(START);
    wait_pub(200, cyc);
    take_pub();
    wait_r(8'h10, 50);
    wait_r(8'h20, 10);
    #2 reset = 1'b0;
    #1;
    chk("mid_r",      64'(r),                64'd0);
    chk("mid_scan",   64'(scanning),         64'd0);
    chk("mid_layout", bus.layout,            64'd0);
    chk("mid_valid",  64'(bus.layout_valid), 64'd0);
`ifdef SCAN_DIFF_EN
    chk("mid_diff",   bus.diff,              64'd0);
`endif
    q.delete();
    prev_pub = 64'd0;

    // Fresh run after reset repeats the start-up timing
    q.push_back(START);
    @(negedge clk);
    run_from_reset("second_pub_lat");
    take_pub();
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
